// File: rtl/alarm_scheduler_if.sv
// Signal bundle between the time-of-day counter / user controls and the alarm scheduler.
// The master side drives time, slot writes and requests; the slave side returns alarm status.
interface alarm_scheduler_if;
    logic [1:0] cur_h1;
    logic [3:0] cur_h0;
    logic [3:0] cur_m1;
    logic [3:0] cur_m0;
    logic [3:0] cur_s1;
    logic [3:0] cur_s0;
    logic       wr_en;
    logic [1:0] wr_slot;
    logic [1:0] wr_h1;
    logic [3:0] wr_h0;
    logic [3:0] wr_m1;
    logic [3:0] wr_m0;
    logic       wr_enable;
    logic       al_on;
    logic       snooze;
    logic       stop;
    logic       alarm;
    logic [1:0] ring_slot;
    logic       snoozing;
    logic [9:0] snooze_left;
    logic [3:0] slot_en;

    modport master (
        output cur_h1, cur_h0, cur_m1, cur_m0, cur_s1, cur_s0,
        output wr_en, wr_slot, wr_h1, wr_h0, wr_m1, wr_m0, wr_enable,
        output al_on, snooze, stop,
        input  alarm, ring_slot, snoozing, snooze_left, slot_en
    );

    modport slave (
        input  cur_h1, cur_h0, cur_m1, cur_m0, cur_s1, cur_s0,
        input  wr_en, wr_slot, wr_h1, wr_h0, wr_m1, wr_m0, wr_enable,
        input  al_on, snooze, stop,
        output alarm, ring_slot, snoozing, snooze_left, slot_en
    );
endinterface

// File: rtl/alarm_scheduler.sv
// Four-slot alarm controller: slot storage, lowest-index match arbitration and the
// IDLE / RING / SNOOZE sequencer driving the buzzer. All outputs are registered.
module alarm_scheduler #(
    parameter int SNOOZE_SEC       = 300,
    parameter int RING_TIMEOUT_SEC = 60
) (
    input  logic               clk_1s,
    input  logic               reset,
    alarm_scheduler_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

    state_t     state_reg;
    logic       alarm_reg;
    logic [1:0] ring_slot_reg;
    logic       snoozing_reg;
    logic [9:0] snooze_left_reg;
    logic [9:0] ring_cnt_reg;

    logic [1:0] slot_h1_reg [4];
    logic [3:0] slot_h0_reg [4];
    logic [3:0] slot_m1_reg [4];
    logic [3:0] slot_m0_reg [4];
    logic       slot_en_reg [4];

    logic [3:0] match;
    logic       any_match;
    logic [1:0] winner;
    logic       top_of_minute;

    assign top_of_minute = (bus.cur_s1 == 4'd0) && (bus.cur_s0 == 4'd0);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            always_ff @(posedge clk_1s or posedge reset) begin
                if (reset) begin
                    slot_h1_reg[gi] <= 2'd0;
                    slot_h0_reg[gi] <= 4'd0;
                    slot_m1_reg[gi] <= 4'd0;
                    slot_m0_reg[gi] <= 4'd0;
                    slot_en_reg[gi] <= 1'b0;
                end else if (bus.wr_en && (bus.wr_slot == 2'(gi))) begin
                    slot_h1_reg[gi] <= bus.wr_h1;
                    slot_h0_reg[gi] <= bus.wr_h0;
                    slot_m1_reg[gi] <= bus.wr_m1;
                    slot_m0_reg[gi] <= bus.wr_m0;
                    slot_en_reg[gi] <= bus.wr_enable;
                end
            end

            // Compares against the stored contents, so a same-edge write only counts next edge.
            assign match[gi] = slot_en_reg[gi] && bus.al_on && top_of_minute &&
                               (bus.cur_h1 == slot_h1_reg[gi]) &&
                               (bus.cur_h0 == slot_h0_reg[gi]) &&
                               (bus.cur_m1 == slot_m1_reg[gi]) &&
                               (bus.cur_m0 == slot_m0_reg[gi]);

            assign bus.slot_en[gi] = slot_en_reg[gi];
        end
    endgenerate

    always_comb begin
        any_match = |match;
        winner    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (match[i]) winner = 2'(i);
        end
    end

    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            alarm_reg       <= 1'b0;
            ring_slot_reg   <= 2'd0;
            snoozing_reg    <= 1'b0;
            snooze_left_reg <= 10'd0;
            ring_cnt_reg    <= 10'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_match) begin
                        state_reg     <= RING;
                        alarm_reg     <= 1'b1;
                        ring_slot_reg <= winner;
                        ring_cnt_reg  <= 10'd0;
                    end
                end
                RING: begin
                    if (bus.stop || !bus.al_on) begin
                        state_reg <= IDLE;
                        alarm_reg <= 1'b0;
                    end else if (bus.snooze) begin
                        state_reg       <= SNOOZE;
                        alarm_reg       <= 1'b0;
                        snoozing_reg    <= 1'b1;
                        snooze_left_reg <= 10'(SNOOZE_SEC);
                    end else if (ring_cnt_reg == 10'(RING_TIMEOUT_SEC - 1)) begin
                        state_reg <= IDLE;
                        alarm_reg <= 1'b0;
                    end else begin
                        ring_cnt_reg <= ring_cnt_reg + 10'd1;
                    end
                end
                SNOOZE: begin
                    if (bus.stop || !bus.al_on) begin
                        state_reg       <= IDLE;
                        snoozing_reg    <= 1'b0;
                        snooze_left_reg <= 10'd0;
                    end else if (any_match || (snooze_left_reg == 10'd1)) begin
                        // A fresh match takes over the ring; otherwise the snoozed slot re-rings.
                        state_reg       <= RING;
                        alarm_reg       <= 1'b1;
                        ring_cnt_reg    <= 10'd0;
                        snoozing_reg    <= 1'b0;
                        snooze_left_reg <= 10'd0;
                        if (any_match) ring_slot_reg <= winner;
                    end else begin
                        snooze_left_reg <= snooze_left_reg - 10'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    alarm_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.alarm       = alarm_reg;
    assign bus.ring_slot   = ring_slot_reg;
    assign bus.snoozing    = snoozing_reg;
    assign bus.snooze_left = snooze_left_reg;
endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed bench for alarm_scheduler: drives BCD time and slot writes directly and
// checks outputs 1 time unit after each rising edge against hand-computed values.
module tb_alarm_scheduler;
    logic clk_1s = 1'b0;
    logic reset  = 1'b1;
    int   n_vec  = 0;
    int   n_bad  = 0;

    alarm_scheduler_if bus ();

    alarm_scheduler #(.SNOOZE_SEC(300), .RING_TIMEOUT_SEC(60)) dut (
        .clk_1s (clk_1s),
        .reset  (reset),
        .bus    (bus.slave)
    );

    always #5 clk_1s = ~clk_1s;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_1s);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_time(input logic [1:0] h1, input logic [3:0] h0, input logic [3:0] m1,
                            input logic [3:0] m0, input logic [3:0] s1, input logic [3:0] s0);
        bus.cur_h1 = h1; bus.cur_h0 = h0; bus.cur_m1 = m1;
        bus.cur_m0 = m0; bus.cur_s1 = s1; bus.cur_s0 = s0;
    endtask

    task automatic arm_write(input logic [1:0] slot, input logic [1:0] h1, input logic [3:0] h0,
                             input logic [3:0] m1, input logic [3:0] m0, input logic en);
        bus.wr_en = 1'b1; bus.wr_slot = slot; bus.wr_h1 = h1; bus.wr_h0 = h0;
        bus.wr_m1 = m1; bus.wr_m0 = m0; bus.wr_enable = en;
    endtask

    task automatic write_slot(input logic [1:0] slot, input logic [1:0] h1, input logic [3:0] h0,
                              input logic [3:0] m1, input logic [3:0] m0, input logic en);
        arm_write(slot, h1, h0, m1, m0, en);
        tick();
        bus.wr_en = 1'b0;
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_slot = 2'd0; bus.wr_h1 = 2'd0; bus.wr_h0 = 4'd0;
        bus.wr_m1 = 4'd0; bus.wr_m0 = 4'd0; bus.wr_enable = 1'b0;
        bus.al_on = 1'b0; bus.snooze = 1'b0; bus.stop = 1'b0;
        set_time(2'd0, 4'd0, 4'd0, 4'd1, 4'd3, 4'd0);

        // Reset state
        tick();
        check("rst_alarm", 32'(bus.alarm), 32'd0);
        check("rst_slot_en", 32'(bus.slot_en), 32'd0);
        check("rst_snooze_left", 32'(bus.snooze_left), 32'd0);
        #2 reset = 1'b0;

        // Slot 1 = 07:30, auto-off after 60 edges
        write_slot(2'd1, 2'd0, 4'd7, 4'd3, 4'd0, 1'b1);
        check("t1_slot_en", 32'(bus.slot_en), 32'b0010);
        bus.al_on = 1'b1;
        set_time(2'd0, 4'd7, 4'd2, 4'd9, 4'd5, 4'd8); tick();
        check("t1_0729_58", 32'(bus.alarm), 32'd0);
        set_time(2'd0, 4'd7, 4'd2, 4'd9, 4'd5, 4'd9); tick();
        check("t1_0729_59", 32'(bus.alarm), 32'd0);
        set_time(2'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0); tick();
        check("t1_ring", 32'(bus.alarm), 32'd1);
        check("t1_ring_slot", 32'(bus.ring_slot), 32'd1);
        set_time(2'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd1);
        ticks(59);
        check("t1_still_on_60th", 32'(bus.alarm), 32'd1);
        tick();
        check("t1_auto_off", 32'(bus.alarm), 32'd0);

        // Slots 0 and 2 at 06:00: lowest wins, stop kills it
        write_slot(2'd0, 2'd0, 4'd6, 4'd0, 4'd0, 1'b1);
        write_slot(2'd2, 2'd0, 4'd6, 4'd0, 4'd0, 1'b1);
        check("t2_slot_en", 32'(bus.slot_en), 32'b0111);
        set_time(2'd0, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0); tick();
        check("t2_ring", 32'(bus.alarm), 32'd1);
        check("t2_arb", 32'(bus.ring_slot), 32'd0);
        set_time(2'd0, 4'd6, 4'd0, 4'd0, 4'd0, 4'd1);
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
        check("t2_stop", 32'(bus.alarm), 32'd0);
        ticks(3);
        check("t2_no_slot2", 32'(bus.alarm), 32'd0);

        // Snooze for 300 edges then re-ring on the same slot
        set_time(2'd0, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0); tick();
        check("t3_ring", 32'(bus.alarm), 32'd1);
        set_time(2'd0, 4'd6, 4'd0, 4'd0, 4'd0, 4'd1);
        bus.snooze = 1'b1; tick(); bus.snooze = 1'b0;
        check("t3_sn_alarm", 32'(bus.alarm), 32'd0);
        check("t3_snoozing", 32'(bus.snoozing), 32'd1);
        check("t3_left_300", 32'(bus.snooze_left), 32'd300);
        tick();
        check("t3_left_299", 32'(bus.snooze_left), 32'd299);
        ticks(298);
        check("t3_left_1", 32'(bus.snooze_left), 32'd1);
        check("t3_still_quiet", 32'(bus.alarm), 32'd0);
        tick();
        check("t3_rering", 32'(bus.alarm), 32'd1);
        check("t3_rering_slot", 32'(bus.ring_slot), 32'd0);
        check("t3_rering_snoozing", 32'(bus.snoozing), 32'd0);

        // stop + snooze together while ringing
        bus.stop = 1'b1; bus.snooze = 1'b1; tick();
        bus.stop = 1'b0; bus.snooze = 1'b0;
        check("t4_alarm", 32'(bus.alarm), 32'd0);
        check("t4_snoozing", 32'(bus.snoozing), 32'd0);
        check("t4_left", 32'(bus.snooze_left), 32'd0);

        // Disabled slot, global disable, al_on drop during ring
        write_slot(2'd3, 2'd0, 4'd8, 4'd0, 4'd0, 1'b0);
        check("t5_slot_en", 32'(bus.slot_en), 32'b0111);
        set_time(2'd0, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0); tick();
        check("t5_disabled_slot", 32'(bus.alarm), 32'd0);
        bus.al_on = 1'b0;
        set_time(2'd0, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0); tick();
        check("t5_al_off", 32'(bus.alarm), 32'd0);
        bus.al_on = 1'b1; tick();
        check("t5_ring", 32'(bus.alarm), 32'd1);
        set_time(2'd0, 4'd6, 4'd0, 4'd0, 4'd0, 4'd1);
        bus.al_on = 1'b0; tick(); bus.al_on = 1'b1;
        check("t5_al_drop", 32'(bus.alarm), 32'd0);

        // Write at match edge: old contents match, new contents apply afterwards
        set_time(2'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0);
        arm_write(2'd1, 2'd0, 4'd7, 4'd3, 4'd0, 1'b0);
        tick(); bus.wr_en = 1'b0;
        check("t6_old_match", 32'(bus.alarm), 32'd1);
        check("t6_slot", 32'(bus.ring_slot), 32'd1);
        check("t6_slot_en", 32'(bus.slot_en), 32'b0101);
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
        tick();
        check("t6_new_disabled", 32'(bus.alarm), 32'd0);

        // Async reset mid-snooze
        write_slot(2'd2, 2'd0, 4'd9, 4'd0, 4'd0, 1'b1);
        set_time(2'd0, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0); tick();
        check("t7_ring_slot", 32'(bus.ring_slot), 32'd2);
        set_time(2'd0, 4'd9, 4'd0, 4'd0, 4'd0, 4'd1);
        bus.snooze = 1'b1; tick(); bus.snooze = 1'b0;
        ticks(5);
        check("t7_left", 32'(bus.snooze_left), 32'd295);
        #2 reset = 1'b1;
        #1;
        check("t7_rst_alarm", 32'(bus.alarm), 32'd0);
        check("t7_rst_slot", 32'(bus.ring_slot), 32'd0);
        check("t7_rst_snoozing", 32'(bus.snoozing), 32'd0);
        check("t7_rst_left", 32'(bus.snooze_left), 32'd0);
        #1 reset = 1'b0;
        tick();
        check("t7_post_slot_en", 32'(bus.slot_en), 32'd0);
        check("t7_post_alarm", 32'(bus.alarm), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/alarm_scheduler.md
# alarm_scheduler

Multi-slot alarm controller that sits beside the time-of-day counter and consumes its BCD time digits. It holds four programmable alarm slots and arbitrates between them when they match the current time. It sequences the ring / snooze / auto-off behaviour and drives a single alarm output for the buzzer and display logic. It replaces the single hard-wired alarm comparator as the owner of all alarm state.

## Interface
Parameters:
- SNOOZE_SEC, 300, snooze length in clk_1s cycles; legal range 1..1023
- RING_TIMEOUT_SEC, 60, auto-off ring length in clk_1s cycles; legal range 1..1023

Ports:
- clk_1s  in  1  1 Hz tick clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high
- cur_h1 / cur_h0 / cur_m1 / cur_m0 / cur_s1 / cur_s0  in  2/4/4/4/4/4  current time, BCD, from the time counter
- wr_en  in  1  write one slot this cycle
- wr_slot  in  2  slot index to write
- wr_h1 / wr_h0 / wr_m1 / wr_m0  in  2/4/4/4  alarm time (BCD) written to the slot
- wr_enable  in  1  enable bit written to the slot together with the time
- al_on  in  1  global alarm enable
- snooze  in  1  snooze request (level, sampled each edge)
- stop  in  1  stop request (level, sampled each edge)
- alarm  out  1  buzzer drive
- ring_slot  out  2  index of the slot currently ringing or snoozed
- snoozing  out  1  high while in SNOOZE
- snooze_left  out  10  seconds of snooze remaining; 0 outside SNOOZE
- slot_en  out  4  per-slot enable bits

## Operation
- Slot storage: 4 entries, each {h1,h0,m1,m0,en}. Writes occur when wr_en=1 at a clock edge. A write never affects a ring or snooze already in progress.
- Slot k matches when all of the following hold: slot_en[k]=1, al_on=1, cur hh:mm equals slot hh:mm, and cur_s1=cur_s0=0.
- Arbitration: when several slots match, the lowest index wins.
- FSM states: IDLE, RING, SNOOZE.
- IDLE:
  - On any match: go to RING, ring_slot <= winner, ring_cnt <= 0.
- RING:
  - alarm=1.
  - Priority order: stop, then al_on=0, then snooze, then timeout.
  - stop=1 or al_on=0: go to IDLE.
  - snooze=1: go to SNOOZE, snooze_left <= SNOOZE_SEC.
  - ring_cnt = RING_TIMEOUT_SEC-1: go to IDLE (auto-off). Otherwise ring_cnt increments.
  - New matches are ignored.
- SNOOZE:
  - alarm=0.
  - stop=1 or al_on=0: go to IDLE, snooze_left <= 0.
  - Else a new match: go to RING with the new winner and ring_cnt <= 0.
  - Else snooze_left=1: go to RING with the same slot and ring_cnt <= 0.
  - Else snooze_left decrements.
- ring_cnt: 10 bits, saturates/clears on every RING entry. snooze_left: 10 bits. Neither counter wraps.
- Reset values: state IDLE, alarm=0, ring_slot=0, snoozing=0, snooze_left=0, slot_en=0, all slot times 00:00.
- Reset asserted mid-ring or mid-snooze returns the block to reset values immediately and asynchronously.

## Timing
- All outputs are registered; none are combinational from inputs.
- The match is sampled at the edge where the inputs show hh:mm:00, and alarm rises at that same edge. Because the time counter advances on the same edge, the display shows hh:mm:01 when alarm first reads high.
- Untouched ring: alarm stays high for exactly RING_TIMEOUT_SEC edges.
- Snooze: alarm is low for exactly SNOOZE_SEC edges, then high again.
- Requests are level inputs. Holding snooze high across a re-ring snoozes again on the first RING edge. stop has priority over snooze when both are high.
- A write at the match edge to a matching slot takes effect from the next edge. The match at that edge uses the old slot contents.

## Test plan
- Load slot 1 = 07:30 enabled, al_on=1, step time 07:29:58 -> 07:30:00: alarm=1 and ring_slot=1 at the 07:30:00 sample edge; alarm auto-clears after 60 edges.
- Slots 0 and 2 both = 06:00 enabled; reach 06:00:00 -> ring_slot=0. Press stop -> alarm=0 next edge, state IDLE, and slot 2 does not ring.
- Ringing, assert snooze one edge -> alarm=0, snoozing=1, snooze_left=300 counting down to 1; alarm=1 again after exactly 300 edges with the same ring_slot.
- Assert stop and snooze on the same edge while ringing -> IDLE, snoozing=0, snooze_left=0.
- Slot 3 disabled (wr_enable=0) with a matching time, or al_on=0 -> no alarm. Drop al_on during RING -> alarm=0 next edge.
- Assert reset mid-snooze -> all outputs 0 immediately, and slot_en=0000 after release.
